// File: rtl/d16_mem.sv
// Unified 32-bit instruction/data memory for the D16 core, with a byte-serial
// program loader that holds the core in reset until the image is in place.
module d16_mem #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] ins_a,
  output logic [31:0] ins_di,
  input  logic [15:0] data_a,
  input  logic        data_we,
  input  logic [15:0] data_do,
  output logic [15:0] data_di,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        cpu_rst
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {CNT_HI, CNT_LO, BYTE, WRITE, DONE} ld_state_t;

  ld_state_t               state_reg, state_next;
  logic [15:0]             count_reg, count_next;
  logic [1:0]              byte_idx_reg, byte_idx_next;
  logic [31:0]             word_reg, word_next;
  logic [15:0]             k_reg, k_next;
  logic                    cpu_rst_reg, ld_done_reg;
  logic [31:0]             ins_di_reg;
  logic [15:0]             data_di_reg;

  logic [31:0]             mem [DEPTH];
  logic [1:0]              wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [31:0]             wr_data;
  logic                    ld_take;

  wire [ADDR_WIDTH-1:0] ins_word  = ins_a[ADDR_WIDTH+1:2];
  wire [ADDR_WIDTH-1:0] data_word = data_a[ADDR_WIDTH+1:2];

  // Low address bits and anything above the word index are deliberately don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ins_a, data_a};

  assign ld_ready = !sys_rst &&
                    (state_reg == CNT_HI || state_reg == CNT_LO || state_reg == BYTE);
  assign ld_take  = ld_valid && ld_ready;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    byte_idx_next = byte_idx_reg;
    word_next     = word_reg;
    k_next        = k_reg;
    case (state_reg)
      CNT_HI: if (ld_take) begin
        count_next = {ld_data, 8'h00};
        state_next = CNT_LO;
      end
      CNT_LO: if (ld_take) begin
        count_next = {count_reg[15:8], ld_data};
        state_next = ({count_reg[15:8], ld_data} == 16'd0) ? DONE : BYTE;
      end
      BYTE: if (ld_take) begin
        word_next     = {word_reg[23:0], ld_data};
        byte_idx_next = byte_idx_reg + 2'd1;
        if (byte_idx_reg == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        k_next     = k_reg + 16'd1;
        // 17-bit compare so a full 65535-word count still terminates.
        state_next = (({1'b0, k_reg} + 17'd1) < {1'b0, count_reg}) ? BYTE : DONE;
      end
      DONE:    state_next = DONE;
      default: state_next = CNT_HI;
    endcase
  end

  // Single write port shared by loader (full word) and core (one halfword).
  always_comb begin
    wr_en   = 2'b00;
    wr_addr = data_word;
    wr_data = {data_do, data_do};
    if (!sys_rst) begin
      if (state_reg == WRITE) begin
        wr_en   = 2'b11;
        wr_addr = k_reg[ADDR_WIDTH-1:0];
        wr_data = word_reg;
      end else if (state_reg == DONE && data_we) begin
        wr_en = data_a[1] ? 2'b10 : 2'b01;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= CNT_HI;
      count_reg    <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      k_reg        <= '0;
      cpu_rst_reg  <= 1'b1;
      ld_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      byte_idx_reg <= byte_idx_next;
      word_reg     <= word_next;
      k_reg        <= k_next;
      cpu_rst_reg  <= (state_next != DONE);
      ld_done_reg  <= (state_next == DONE);
    end
  end

  // Array is intentionally outside reset so a re-load keeps prior contents.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) mem[wr_addr][i*16 +: 16] <= wr_data[i*16 +: 16];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ins_di_reg  <= '0;
      data_di_reg <= '0;
    end else begin
      ins_di_reg  <= mem[ins_word];
      data_di_reg <= data_a[1] ? mem[data_word][31:16] : mem[data_word][15:0];
    end
  end

  assign ins_di  = ins_di_reg;
  assign data_di = data_di_reg;
  assign cpu_rst = cpu_rst_reg;
  assign ld_done = ld_done_reg;

endmodule

// File: tb/tb_d16_mem.sv
// Directed bench for d16_mem: loader sequencing, halfword writes,
// read-before-write, aliasing and reset behaviour.
module tb_d16_mem;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] ins_a;
  logic [31:0] ins_di;
  logic [15:0] data_a;
  logic        data_we;
  logic [15:0] data_do;
  logic [15:0] data_di;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        cpu_rst;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 sys_clk = ~sys_clk;

  // Narrow array so address bit 14 exercises aliasing.
  d16_mem #(.ADDR_WIDTH(12)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ins_a    (ins_a),
    .ins_di   (ins_di),
    .data_a   (data_a),
    .data_we  (data_we),
    .data_do  (data_do),
    .data_di  (data_di),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .cpu_rst  (cpu_rst)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  // Presents a byte and waits (bounded) until the loader takes it; ld_valid stays high.
  task automatic send_byte(input logic [7:0] b);
    bit taken = 1'b0;
    ld_valid = 1'b1;
    ld_data  = b;
    for (int t = 0; t < 16 && !taken; t++) begin
      if (ld_ready) taken = 1'b1;
      tick();
    end
    if (!taken) check_val("ld_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_ins(input logic [15:0] a, input logic [31:0] exp, input string tag);
    ins_a = a;
    tick();
    check_val(tag, ins_di, exp);
  endtask

  task automatic rd_data(input logic [15:0] a, input logic [15:0] exp, input string tag);
    data_a = a;
    tick();
    check_val(tag, {16'h0, data_di}, {16'h0, exp});
  endtask

  task automatic wr_data(input logic [15:0] a, input logic [15:0] d);
    data_a  = a;
    data_do = d;
    data_we = 1'b1;
    tick();
    data_we = 1'b0;
  endtask

  task automatic do_reset();
    ld_valid = 1'b0;
    sys_rst  = 1'b1;
    tick();
    sys_rst  = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] img2 [10];
    logic [7:0] img1 [6];
    img2 = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    img1 = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    sys_rst = 1'b1; ins_a = '0; data_a = '0; data_we = 1'b0; data_do = '0;
    ld_valid = 1'b0; ld_data = '0;
    tick();
    check_val("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check_val("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    check_val("rst_ld_done",  {31'd0, ld_done},  32'd0);
    check_val("rst_ins_di",   ins_di,            32'd0);
    check_val("rst_data_di",  {16'h0, data_di},  32'd0);
    sys_rst = 1'b0;
    #1;
    check_val("cnt_hi_ready", {31'd0, ld_ready}, 32'd1);

    // N=2 load with ld_valid held high throughout; byte 11 arrives during WRITE.
    for (int i = 0; i < 10; i++) send_byte(img2[i]);
    check_val("write_cpu_rst", {31'd0, cpu_rst},  32'd1);
    check_val("write_ready",   {31'd0, ld_ready}, 32'd0);
    tick();
    check_val("done_cpu_rst",  {31'd0, cpu_rst},  32'd0);
    check_val("done_ld_done",  {31'd0, ld_done},  32'd1);
    check_val("done_ready",    {31'd0, ld_ready}, 32'd0);
    tick();
    ld_valid = 1'b0;

    rd_ins(16'h0000, 32'hAABBCCDD, "mem0");
    rd_ins(16'h0004, 32'h11223344, "mem1");
    rd_ins(16'h0007, 32'h11223344, "mem1_lowbits");
    rd_ins(16'h4004, 32'h11223344, "mem1_alias");
    rd_data(16'h0006, 16'h1122, "mem1_hi");
    rd_data(16'h0004, 16'h3344, "mem1_lo");
    rd_data(16'h0007, 16'h1122, "mem1_hi_b0");
    rd_data(16'h4006, 16'h1122, "mem1_hi_alias");

    // Halfword writes: build 0x3344AABB then replace the upper half.
    wr_data(16'h0012, 16'h3344);
    wr_data(16'h0010, 16'hAABB);
    rd_ins(16'h0010, 32'h3344AABB, "w4_built");
    wr_data(16'h0012, 16'hBEEF);
    rd_ins(16'h0010, 32'hBEEFAABB, "w4_hi_wr");
    rd_data(16'h0010, 16'hAABB, "w4_lo_kept");

    // Read-before-write across ports, then on the data port itself.
    ins_a = 16'h0004; data_a = 16'h0006; data_do = 16'h5566; data_we = 1'b1;
    tick();
    data_we = 1'b0;
    check_val("rbw_ins_old", ins_di, 32'h11223344);
    tick();
    check_val("rbw_ins_new", ins_di, 32'h55663344);
    data_a = 16'h0006; data_do = 16'h7788; data_we = 1'b1;
    tick();
    data_we = 1'b0;
    check_val("rbw_data_old", {16'h0, data_di}, 32'h00005566);
    tick();
    check_val("rbw_data_new", {16'h0, data_di}, 32'h00007788);

    // Reset from DONE: loader restarts, memory persists, core writes blocked.
    do_reset();
    check_val("rst2_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    check_val("rst2_ld_done",  {31'd0, ld_done},  32'd0);
    check_val("rst2_data_di",  {16'h0, data_di},  32'd0);
    wr_data(16'h0000, 16'h0000);
    rd_ins(16'h0000, 32'hAABBCCDD, "blocked_wr");

    // Abort after 3 of 4 bytes.
    for (int i = 0; i < 5; i++) send_byte(8'h12 + 8'(i));
    do_reset();
    check_val("abort_ready",   {31'd0, ld_ready}, 32'd1);
    check_val("abort_cpu_rst", {31'd0, cpu_rst},  32'd1);
    rd_ins(16'h0000, 32'hAABBCCDD, "abort_mem0");

    // Fresh N=1 load with random idle gaps between bytes.
    for (int i = 0; i < 6; i++) begin
      send_byte(img1[i]);
      ld_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    check_val("n1_ld_done", {31'd0, ld_done}, 32'd1);
    check_val("n1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    rd_ins(16'h0000, 32'hDEADBEEF, "n1_mem0");
    rd_ins(16'h0004, 32'h77883344, "n1_mem1_kept");

    // N=0: DONE straight after the count, no writes.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    check_val("n0_ld_done", {31'd0, ld_done}, 32'd1);
    check_val("n0_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check_val("n0_ready",   {31'd0, ld_ready}, 32'd0);
    rd_ins(16'h0000, 32'hDEADBEEF, "n0_mem0");
    ld_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/d16_mem.md
D16_MEM -- requirements
Module: d16_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, SHALL set word-address width; depth 2^ADDR_WIDTH words of 32 bits.
REQ-002 sys_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 sys_rst  input  1  reset, synchronous, active-high.
REQ-004 ins_a  input  16  instruction byte address from core; word index ins_a[ADDR_WIDTH+1:2].
REQ-005 ins_di  output  32  instruction word to core.
REQ-006 data_a  input  16  data byte address; word index data_a[ADDR_WIDTH+1:2], halfword select data_a[1].
REQ-007 data_we  input  1  data write enable from core.
REQ-008 data_do  input  16  write data from core.
REQ-009 data_di  output  16  read data to core.
REQ-010 ld_valid  input  1  loader byte strobe.
REQ-011 ld_data  input  8  loader byte.
REQ-012 ld_ready  output  1  loader can accept a byte this cycle.
REQ-013 ld_done  output  1  program load complete.
REQ-014 cpu_rst  output  1  reset to core, held high until load complete.

Function
REQ-015 Instruction port SHALL register mem[ins_a word] into ins_di one cycle after ins_a is presented; ins_a[1:0] ignored.
REQ-016 Data read SHALL register mem[word][31:16] into data_di when data_a[1]=1, else mem[word][15:0], one cycle latency; data_a[0] ignored.
REQ-017 Core write with data_we=1 SHALL replace only the selected halfword (data_a[1]=1: bits 31:16, else 15:0); other half unchanged.
REQ-018 Same-cycle read and write of one word (either port) SHALL return the pre-write contents (read-before-write).
REQ-019 Address bits above ADDR_WIDTH+1 SHALL be ignored (aliasing, wrap modulo depth).
REQ-020 Loader FSM states: CNT_HI, CNT_LO, BYTE, WRITE, DONE.
REQ-021 Byte transfer occurs in a cycle with ld_valid=1 and ld_ready=1; ld_ready=1 exactly in CNT_HI, CNT_LO, BYTE.
REQ-022 CNT_HI captures count N[15:8] -> CNT_LO; CNT_LO captures N[7:0] -> BYTE if N!=0, else DONE.
REQ-023 BYTE accepts 4 bytes big-endian (first byte -> bits 31:24); after 4th byte -> WRITE.
REQ-024 WRITE SHALL write the assembled word to word index k (k=0 for first word, +1 per word, wrap modulo depth), lasting exactly one cycle; then BYTE if k+1<N, else DONE.
REQ-025 DONE is terminal until sys_rst; ld_done=1, cpu_rst=0, further ld_valid ignored.
REQ-026 cpu_rst SHALL equal 1 in every state except DONE, registered (falls the cycle DONE is entered).
REQ-027 While not DONE, core data writes SHALL be ignored; reads still served.
REQ-028 ld_valid with ld_ready=0 SHALL not consume the byte; no stall timeout.

Reset
REQ-029 On sys_rst=1: FSM -> CNT_HI, byte index 0, k=0, N=0, ins_di=0, data_di=0, ld_done=0, cpu_rst=1, ld_ready=0 during reset cycle.
REQ-030 sys_rst mid-load SHALL abort the load; partially loaded words remain; memory array is never cleared by reset.
REQ-031 Memory contents SHALL persist across sys_rst.

Verification
REQ-032 Load N=2, bytes AA BB CC DD 11 22 33 44 -> mem[0]=0xAABBCCDD, mem[1]=0x11223344, ld_done=1, cpu_rst falls after second WRITE.
REQ-033 Load N=0 (bytes 00 00) -> DONE next cycle, no writes, cpu_rst=0.
REQ-034 After DONE, data_we=1, data_a=0x0012, data_do=0xBEEF on word 0x3344AABB -> word becomes 0xBEEFAABB; read data_a=0x0010 next -> data_di=0xAABB.
REQ-035 Simultaneous ins_a=0x0004 and data write to 0x0006 -> ins_di returns old word; following cycle returns updated word.
REQ-036 ld_valid held high with random gaps, byte presented during WRITE -> byte held, accepted next BYTE cycle, no loss or duplication.
REQ-037 sys_rst asserted after 3 of 4 bytes -> FSM CNT_HI, cpu_rst=1, mem[0] unchanged; fresh load then succeeds.
